load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory interface: takes one load/store request from the core,
//  drives a word-aligned request with byte enables to the data memory, and waits for mem_ack.
//  Returns load data extracted and sign/zero-extended per RISC-V funct3 (LB/LH/LW/LBU/LHU),
//  and lane-shifts store data (SB/SH/SW).
//  Flags misaligned or illegal accesses and memory timeouts. Sits between the execute stage
//  and the data memory.
// PARAMETERS
//  MAX_WAIT   16   cycles in ACCESS without mem_ack before a timeout error (>=2)
// PORTS
//  clock       in   1   single clock, all logic on posedge
//  reset       in   1   synchronous, active-high
//  req_valid   in   1   core request present
//  req_ready   out  1   unit can accept; = (state==IDLE)
//  req_write   in   1   1 = store, 0 = load
//  req_funct3  in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified
//  resp_valid  out  1   one-cycle completion pulse
//  resp_rdata  out  32  extended load data; 0 for stores and errors
//  resp_err    out  1   valid with resp_valid: misaligned, illegal funct3, or timeout
//  mem_req     out  1   memory request, held until ack or timeout
//  mem_we      out  1   write strobe, qualified by mem_req
//  mem_addr    out  32  {req_addr[31:2],2'b00}
//  mem_be      out  4   byte enables, bit i = byte lane i
//  mem_wdata   out  32  lane-shifted store data
//  mem_ack     in   1   memory done; sampled only in ACCESS
//  mem_rdata   in   32  read word, valid in the mem_ack cycle
// BEHAVIOUR
//  Reset: state IDLE, wait counter 0. mem_req, mem_we, mem_be, mem_addr, mem_wdata,
//   resp_valid, resp_rdata and resp_err are all 0. req_ready is 1.
//   Reset in any state aborts the access: mem_req is 0 next cycle and no resp_valid follows.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE, or IDLE -> RESP directly on an error.
//  IDLE: accept on req_valid&req_ready (cycle 0). Latch addr, funct3, write and wdata.
//   Error check: H needs addr[0]==0. W needs addr[1:0]==0. funct3 011/110/111 is illegal.
//   A store with funct3[2]==1 is illegal.
//   On error: cycle 1 = RESP with resp_err=1 and resp_rdata=0; mem_req is never raised.
//   Otherwise: cycle 1 = ACCESS.
//  ACCESS: mem_req=1. mem_we, mem_addr, mem_be and mem_wdata are registered and stable
//   until exit.
//   lane = addr[1:0]. B: be = 4'b0001<<lane. H: be = 4'b0011<<lane. W: be = 4'b1111.
//   Loads use the same be.
//   mem_wdata = req_wdata << (8*lane); lanes not enabled are don't-care, driven as shifted value.
//   Counter increments each ACCESS cycle. mem_ack in cycle k -> capture mem_rdata,
//   RESP in cycle k+1.
//   Minimum latency: ack in cycle 1 gives resp in cycle 2.
//   No ack for MAX_WAIT cycles -> RESP with resp_err=1; mem_req is 0 in the RESP cycle.
//   mem_ack in the final (MAX_WAIT-th) cycle wins over timeout: normal response.
//  RESP: resp_valid=1 for exactly one cycle, mem_req=0, req_ready=0. Next cycle is IDLE.
//   resp_valid, resp_rdata and resp_err return to 0 in IDLE.
//  Load extract, with byte b = rdata[8*lane+:8] and half h = rdata[8*lane+:16]:
//   LB {24{b[7]},b}, LBU {24'b0,b}, LH {16{h[15]},h}, LHU {16'b0,h}, LW rdata.
//  req_ready=0 in ACCESS and RESP; requests there are not accepted and must be held by the core.
//  mem_ack outside ACCESS is ignored. At most one access is outstanding.
// TESTING
//  1 SB addr 0x05 wdata 0x000000AB, ack in cycle 3 -> mem_addr 0x04, be 0010,
//    wdata 0x0000AB00, we=1; resp_valid only in cycle 4, err=0.
//  2 Loads with mem_rdata=0x80112233: LB 0x07 -> 0xFFFFFF80; LBU 0x07 -> 0x00000080;
//    LH 0x02 -> 0xFFFF8011; LHU 0x00 -> 0x00002233; LW 0x00 -> 0x80112233.
//  3 LW 0x06, SH 0x03, funct3=011 -> resp_err=1 in cycle 1, mem_req never 1, resp_rdata=0.
//  4 LW 0x10 with no ack -> mem_req high for cycles 1..16, resp_err=1 in cycle 17;
//    repeat with ack in cycle 16 -> err=0, data returned.
//  5 reset in cycle 2 of ACCESS -> mem_req 0 next cycle, no resp_valid, req_ready=1 after reset.
//  6 req_valid held high across two requests, ack in cycle 1 -> second accepted in cycle 3,
//    its mem_req in cycle 4; strays on mem_ack in IDLE have no effect.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-request / response / data-memory signal bundle for the load-store unit.
// master = the unit itself; slave = the core plus data memory facing it.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load-store unit: one outstanding word-aligned data-memory access with byte enables,
// load extraction/extension, store lane shifting, and misalign/illegal/timeout errors.
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 16
) (
  input logic               clock,
  input logic               reset,
  load_store_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;
  logic              write_q;
  logic              ready_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [31:0]       mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;

  logic [1:0]        lane_c;
  logic [3:0]        be_c;
  logic              illegal_c;
  logic [31:0]       wdata_c;
  logic [31:0]       shifted_c;
  logic [31:0]       load_c;

  // Request decode: byte enables, alignment/funct3 legality, store lane shift
  always_comb begin
    lane_c    = bus.req_addr[1:0];
    be_c      = 4'b0000;
    illegal_c = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b100: be_c = 4'b0001 << lane_c;
      3'b001, 3'b101: begin
        be_c      = 4'b0011 << lane_c;
        illegal_c = bus.req_addr[0];
      end
      3'b010: begin
        be_c      = 4'b1111;
        illegal_c = (lane_c != 2'b00);
      end
      default: illegal_c = 1'b1;
    endcase
    if (bus.req_write && bus.req_funct3[2]) illegal_c = 1'b1;
    wdata_c = bus.req_wdata << {lane_c, 3'b000};
  end

  // Load extraction; shifting first keeps the selected byte/half at bit 0
  always_comb begin
    shifted_c = bus.mem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b100:  load_c = {24'b0, shifted_c[7:0]};
      3'b001:  load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b101:  load_c = {16'b0, shifted_c[15:0]};
      default: load_c = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      funct3_q     <= 3'b000;
      lane_q       <= 2'b00;
      write_q      <= 1'b0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            ready_q  <= 1'b0;
            funct3_q <= bus.req_funct3;
            lane_q   <= lane_c;
            write_q  <= bus.req_write;
            wait_cnt <= '0;
            if (illegal_c) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else begin
              state       <= ACCESS;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.req_write;
              mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
              mem_be_q    <= be_c;
              mem_wdata_q <= wdata_c;
            end
          end
        end
        ACCESS: begin
          // An ack in the last allowed cycle still completes normally
          if (bus.mem_ack) begin
            state        <= RESP;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= write_q ? 32'h0 : load_c;
          end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
            state        <= RESP;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state        <= IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule
